// File: rtl/syscall_sequencer.sv
// syscall_sequencer: multi-cycle SYSCALL sequencer for the single-cycle CPU.
// Freezes the core (stall_o), runs a valid/ready console transaction and, for
// INPUT_INT, writes the returned word to $v0 before releasing the core for one
// cycle.
// Optional feature macro: SYSCALL_TIMEOUT_EN (I/O wait limit of TimeoutCycles).
// SysOpW defaults to 4 so that the EXIT code (10) is representable.
module syscall_sequencer #(
    parameter int unsigned SysOpW     = 4,
    parameter int unsigned OpPrintInt = 1,
    parameter int unsigned OpInputInt = 5,
    parameter int unsigned OpExit     = 10
`ifdef SYSCALL_TIMEOUT_EN
    , parameter int unsigned TimeoutCycles = 1024
`endif
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              syscall_i,
    input  logic [SysOpW-1:0] sys_op_i,
    input  logic [31:0]       arg_data_i,
    output logic              stall_o,
    output logic              io_req_valid_o,
    input  logic              io_req_ready_i,
    output logic              io_req_op_o,
    output logic [31:0]       io_req_data_o,
    input  logic              io_rsp_valid_i,
    input  logic [31:0]       io_rsp_data_i,
    output logic              sc_reg_we_o,
    output logic [31:0]       sc_reg_wdata_o,
    output logic              exit_req_o,
    output logic              err_op_o,
    output logic              err_timeout_o
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWaitRsp,
        StWb,
        StDone,
        StHalted
    } state_e;

    state_e      state_q;
    logic        stall_q;
    logic        io_req_valid_q;
    logic        io_req_op_q;
    logic [31:0] io_req_data_q;
    logic        sc_reg_we_q;
    logic [31:0] sc_reg_wdata_q;
    logic        exit_req_q;
    logic        err_op_q;
    logic        err_timeout_q;

`ifdef SYSCALL_TIMEOUT_EN
    localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    logic [CntW-1:0] cnt_q;
`endif

    // Sequencer FSM with registered outputs; the $v0 write strobe is a one-cycle pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            stall_q        <= 1'b0;
            io_req_valid_q <= 1'b0;
            io_req_op_q    <= 1'b0;
            io_req_data_q  <= '0;
            sc_reg_we_q    <= 1'b0;
            sc_reg_wdata_q <= '0;
            exit_req_q     <= 1'b0;
            err_op_q       <= 1'b0;
            err_timeout_q  <= 1'b0;
`ifdef SYSCALL_TIMEOUT_EN
            cnt_q          <= '0;
`endif
        end else begin
            sc_reg_we_q    <= 1'b0;
            sc_reg_wdata_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (syscall_i) begin
                        if (sys_op_i == SysOpW'(OpPrintInt)) begin
                            state_q        <= StReq;
                            stall_q        <= 1'b1;
                            io_req_valid_q <= 1'b1;
                            io_req_op_q    <= 1'b0;
                            io_req_data_q  <= arg_data_i;
                        end else if (sys_op_i == SysOpW'(OpInputInt)) begin
                            state_q        <= StReq;
                            stall_q        <= 1'b1;
                            io_req_valid_q <= 1'b1;
                            io_req_op_q    <= 1'b1;
                            io_req_data_q  <= '0;
                        end else if (sys_op_i == SysOpW'(OpExit)) begin
                            state_q    <= StHalted;
                            stall_q    <= 1'b1;
                            exit_req_q <= 1'b1;
                        end else begin
                            state_q  <= StDone;
                            stall_q  <= 1'b0;
                            err_op_q <= 1'b1;
                        end
`ifdef SYSCALL_TIMEOUT_EN
                        cnt_q <= '0;
`endif
                    end
                end
                StReq: begin
                    if (io_req_ready_i) begin
                        io_req_valid_q <= 1'b0;
                        io_req_op_q    <= 1'b0;
                        io_req_data_q  <= '0;
                        if (io_req_op_q) begin
                            state_q <= StWaitRsp;
                        end else begin
                            state_q <= StDone;
                            stall_q <= 1'b0;
                        end
`ifdef SYSCALL_TIMEOUT_EN
                        cnt_q <= '0;
                    end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
                        state_q        <= StDone;
                        stall_q        <= 1'b0;
                        io_req_valid_q <= 1'b0;
                        io_req_op_q    <= 1'b0;
                        io_req_data_q  <= '0;
                        err_timeout_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
`endif
                    end
                end
                StWaitRsp: begin
                    if (io_rsp_valid_i) begin
                        state_q        <= StWb;
                        sc_reg_we_q    <= 1'b1;
                        sc_reg_wdata_q <= io_rsp_data_i;
`ifdef SYSCALL_TIMEOUT_EN
                    end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
                        state_q       <= StDone;
                        stall_q       <= 1'b0;
                        err_timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
`endif
                    end
                end
                StWb: begin
                    state_q <= StDone;
                    stall_q <= 1'b0;
                end
                StDone: begin
                    // syscall_i is still high here and belongs to the retiring instruction.
                    state_q <= StIdle;
                end
                StHalted: begin
                    state_q <= StHalted;
                end
                default: begin
                    state_q <= StIdle;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    // In IDLE the stall follows the decoder directly so an unserviced SYSCALL never retires.
    always_comb begin
        stall_o = (state_q == StIdle) ? syscall_i : stall_q;
    end

    // Remaining outputs come straight from their registers.
    always_comb begin
        io_req_valid_o = io_req_valid_q;
        io_req_op_o    = io_req_op_q;
        io_req_data_o  = io_req_data_q;
        sc_reg_we_o    = sc_reg_we_q;
        sc_reg_wdata_o = sc_reg_wdata_q;
        exit_req_o     = exit_req_q;
        err_op_o       = err_op_q;
        err_timeout_o  = err_timeout_q;
    end

endmodule

// File: tb/tb_syscall_sequencer.sv
// tb_syscall_sequencer: self-checking bench for syscall_sequencer.
// Expected behaviour is a transaction-level timeline built from the service rules
// (cycles per phase, which outputs are active in each phase, sticky error flags).
// Build with SYSCALL_TIMEOUT_EN defined to exercise the timeout path (limit 8).
module tb_syscall_sequencer;

    localparam int unsigned SysOpW = 4;
    localparam logic [SysOpW-1:0] CodePrint = 4'd1;
    localparam logic [SysOpW-1:0] CodeRead  = 4'd5;
    localparam logic [SysOpW-1:0] CodeExit  = 4'd10;
`ifdef SYSCALL_TIMEOUT_EN
    localparam int unsigned TimeoutCycles = 8;
`endif

    logic              clk;
    logic              rst_n;
    logic              syscall;
    logic [SysOpW-1:0] sys_op;
    logic [31:0]       arg_data;
    logic              stall;
    logic              io_req_valid;
    logic              io_req_ready;
    logic              io_req_op;
    logic [31:0]       io_req_data;
    logic              io_rsp_valid;
    logic [31:0]       io_rsp_data;
    logic              sc_reg_we;
    logic [31:0]       sc_reg_wdata;
    logic              exit_req;
    logic              err_op;
    logic              err_timeout;

    int n_checks = 0;
    int n_fails  = 0;
    bit exp_err_op;
    bit exp_err_timeout;

    syscall_sequencer #(
        .SysOpW(SysOpW)
`ifdef SYSCALL_TIMEOUT_EN
        , .TimeoutCycles(TimeoutCycles)
`endif
    ) u_dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .syscall_i      (syscall),
        .sys_op_i       (sys_op),
        .arg_data_i     (arg_data),
        .stall_o        (stall),
        .io_req_valid_o (io_req_valid),
        .io_req_ready_i (io_req_ready),
        .io_req_op_o    (io_req_op),
        .io_req_data_o  (io_req_data),
        .io_rsp_valid_i (io_rsp_valid),
        .io_rsp_data_i  (io_rsp_data),
        .sc_reg_we_o    (sc_reg_we),
        .sc_reg_wdata_o (sc_reg_wdata),
        .exit_req_o     (exit_req),
        .err_op_o       (err_op),
        .err_timeout_o  (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check one cycle of outputs (inputs already driven), then advance one clock.
    task automatic cycle(input string tag, input bit e_stall, input bit e_valid, input bit e_op,
                         input logic [31:0] e_data, input bit e_we, input logic [31:0] e_wdata,
                         input bit e_exit);
        #1;
        chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
        chk({tag, ".req_valid"}, 32'(io_req_valid), 32'(e_valid));
        if (e_valid) begin
            chk({tag, ".req_op"}, 32'(io_req_op), 32'(e_op));
            chk({tag, ".req_data"}, io_req_data, e_data);
        end
        chk({tag, ".we"}, 32'(sc_reg_we), 32'(e_we));
        chk({tag, ".wdata"}, sc_reg_wdata, e_wdata);
        chk({tag, ".exit"}, 32'(exit_req), 32'(e_exit));
        chk({tag, ".err_op"}, 32'(err_op), 32'(exp_err_op));
        chk({tag, ".err_timeout"}, 32'(err_timeout), 32'(exp_err_timeout));
        step();
    endtask

    // Assert reset mid-cycle and check every output is cleared immediately.
    task automatic apply_reset(input string tag);
        #2;
        rst_n        = 1'b0;
        syscall      = 1'b0;
        io_req_ready = 1'b0;
        io_rsp_valid = 1'b0;
        exp_err_op      = 1'b0;
        exp_err_timeout = 1'b0;
        #1;
        chk({tag, ".stall"}, 32'(stall), 32'd0);
        chk({tag, ".req_valid"}, 32'(io_req_valid), 32'd0);
        chk({tag, ".req_op"}, 32'(io_req_op), 32'd0);
        chk({tag, ".req_data"}, io_req_data, 32'd0);
        chk({tag, ".we"}, 32'(sc_reg_we), 32'd0);
        chk({tag, ".wdata"}, sc_reg_wdata, 32'd0);
        chk({tag, ".exit"}, 32'(exit_req), 32'd0);
        chk({tag, ".err_op"}, 32'(err_op), 32'd0);
        chk({tag, ".err_timeout"}, 32'(err_timeout), 32'd0);
        step();
        rst_n = 1'b1;
    endtask

    // One SYSCALL from its IDLE cycle through DONE (exit is handled by the caller).
    // ready_dly: REQ cycles before ready; rsp_dly: WAIT_RSP cycles before the response.
    task automatic do_syscall(input logic [SysOpW-1:0] op, input logic [31:0] arg,
                              input int ready_dly, input int rsp_dly,
                              input logic [31:0] rsp_word);
        bit          is_read;
        logic [31:0] exp_data;
        is_read  = (op == CodeRead);
        exp_data = is_read ? 32'd0 : arg;
        syscall      = 1'b1;
        sys_op       = op;
        arg_data     = arg;
        io_req_ready = 1'b0;
        io_rsp_valid = 1'b0;
        cycle("idle_take", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        if (op == CodeExit) return;
        if (op != CodePrint && op != CodeRead) begin
            exp_err_op = 1'b1;
            cycle("unk_done", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
            return;
        end
        for (int i = 0; i <= ready_dly; i++) begin
            io_req_ready = (i == ready_dly);
            io_rsp_valid = 1'($urandom_range(0, 1));
            io_rsp_data  = $urandom;
            cycle("req", 1'b1, 1'b1, is_read, exp_data, 1'b0, 32'd0, 1'b0);
        end
        io_req_ready = 1'b0;
        io_rsp_valid = 1'b0;
        if (is_read) begin
            for (int i = 0; i <= rsp_dly; i++) begin
                io_rsp_valid = (i == rsp_dly);
                io_rsp_data  = (i == rsp_dly) ? rsp_word : $urandom;
                cycle("wait_rsp", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
            end
            io_rsp_valid = 1'b0;
            io_rsp_data  = $urandom;
            cycle("wb", 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, rsp_word, 1'b0);
        end
        cycle("done", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic idle_cycles(input int n);
        syscall = 1'b0;
        for (int i = 0; i < n; i++) begin
            cycle("idle", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        end
    endtask

    initial begin
        logic [SysOpW-1:0] op;
        int                sel;
        int                max_dly;
        rst_n           = 1'b0;
        syscall         = 1'b0;
        sys_op          = '0;
        arg_data        = '0;
        io_req_ready    = 1'b0;
        io_rsp_valid    = 1'b0;
        io_rsp_data     = '0;
        exp_err_op      = 1'b0;
        exp_err_timeout = 1'b0;

        // Reset state before any clock edge.
        #2;
        chk("reset.stall", 32'(stall), 32'd0);
        chk("reset.req_valid", 32'(io_req_valid), 32'd0);
        chk("reset.we", 32'(sc_reg_we), 32'd0);
        chk("reset.exit", 32'(exit_req), 32'd0);
        chk("reset.err_op", 32'(err_op), 32'd0);
        chk("reset.err_timeout", 32'(err_timeout), 32'd0);
        step();
        rst_n = 1'b1;
        idle_cycles(2);

        // Print 0x2A, ready on the third REQ cycle.
        do_syscall(CodePrint, 32'h0000_002A, 2, 0, 32'd0);
        idle_cycles(1);
        // Read returning 0xFFFFFFF9.
        do_syscall(CodeRead, 32'h1234_5678, 0, 1, 32'hFFFF_FFF9);
        idle_cycles(1);
        // Unknown code 7, then a back-to-back print that must still work.
        do_syscall(4'd7, 32'h0, 0, 0, 32'd0);
        do_syscall(CodePrint, 32'hDEAD_BEEF, 0, 0, 32'd0);
        idle_cycles(1);

        // Randomised SYSCALL stream; responses stay within the timeout when enabled.
`ifdef SYSCALL_TIMEOUT_EN
        max_dly = TimeoutCycles - 1;
`else
        max_dly = 10;
`endif
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 4);
            if (sel <= 1) begin
                op = CodePrint;
            end else if (sel <= 3) begin
                op = CodeRead;
            end else begin
                op = SysOpW'($urandom_range(0, 15));
                if (op == CodePrint || op == CodeRead || op == CodeExit) op = 4'd15;
            end
            do_syscall(op, $urandom, $urandom_range(0, max_dly), $urandom_range(0, max_dly),
                       $urandom);
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
        end
        idle_cycles(1);

        // Reset while waiting for a read response; a late response must not write.
        syscall      = 1'b1;
        sys_op       = CodeRead;
        arg_data     = 32'h0;
        cycle("mr_idle", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        io_req_ready = 1'b1;
        cycle("mr_req", 1'b1, 1'b1, 1'b1, 32'd0, 1'b0, 32'd0, 1'b0);
        io_req_ready = 1'b0;
        cycle("mr_wait", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        apply_reset("mr_reset");
        io_rsp_valid = 1'b1;
        io_rsp_data  = 32'hCAFE_F00D;
        cycle("mr_late_rsp", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        io_rsp_valid = 1'b0;
        idle_cycles(2);

`ifdef SYSCALL_TIMEOUT_EN
        // Read with no response: DONE after TimeoutCycles WAIT_RSP cycles, no write.
        syscall      = 1'b1;
        sys_op       = CodeRead;
        cycle("to_idle", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        io_req_ready = 1'b1;
        cycle("to_req", 1'b1, 1'b1, 1'b1, 32'd0, 1'b0, 32'd0, 1'b0);
        io_req_ready = 1'b0;
        for (int i = 0; i < TimeoutCycles; i++) begin
            cycle("to_wait", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        end
        exp_err_timeout = 1'b1;
        cycle("to_done", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        idle_cycles(1);
        // Print never accepted: request dropped after TimeoutCycles REQ cycles.
        syscall  = 1'b1;
        sys_op   = CodePrint;
        arg_data = 32'h0000_0055;
        cycle("toq_idle", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < TimeoutCycles; i++) begin
            cycle("toq_req", 1'b1, 1'b1, 1'b0, 32'h0000_0055, 1'b0, 32'd0, 1'b0);
        end
        cycle("toq_done", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        idle_cycles(1);
`else
        // Without the timeout a read with no response keeps the core stalled.
        syscall      = 1'b1;
        sys_op       = CodeRead;
        cycle("nto_idle", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        io_req_ready = 1'b1;
        cycle("nto_req", 1'b1, 1'b1, 1'b1, 32'd0, 1'b0, 32'd0, 1'b0);
        io_req_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycle("nto_wait", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        end
        apply_reset("nto_reset");
        idle_cycles(1);
`endif

        // Exit: halted for good until reset.
        do_syscall(CodeExit, 32'h0, 0, 0, 32'd0);
        for (int i = 0; i < 100; i++) begin
            io_req_ready = 1'($urandom_range(0, 1));
            io_rsp_valid = 1'($urandom_range(0, 1));
            cycle("halted", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        end
        apply_reset("exit_reset");
        idle_cycles(2);
        do_syscall(CodePrint, 32'h0000_0001, 1, 0, 32'd0);
        idle_cycles(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
